// File: rtl/div_iter_pkg.sv
// Shared constants and state encoding for the iterative divider.
package div_iter_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic        DIV_START            = 1'b1;
    localparam logic        DIV_STOP             = 1'b0;
    localparam logic        DIV_RESULT_READY     = 1'b1;
    localparam logic        DIV_RESULT_NOT_READY = 1'b0;
    localparam logic        RST_ENABLE           = 1'b1;
    localparam logic [31:0] ZERO_WORD            = 32'h0000_0000;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift the quotient bit in.
module div_step #(
    parameter int unsigned DW = 32
) (
    input  logic [DW-1:0] rem,
    input  logic [DW-1:0] quot,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] rem_next_c,
    output logic [DW-1:0] quot_next_c
);

    logic [DW:0] trial;
    logic [DW:0] diff;
    logic        fits;

    // Partial remainder stays below the divisor, so the trial fits in DW+1 bits
    // and the borrow bit of the subtraction is the compare result.
    always_comb begin
        trial       = {rem, quot[DW-1]};
        diff        = trial - {1'b0, divisor};
        fits        = ~diff[DW];
        rem_next_c  = fits ? diff[DW-1:0] : trial[DW-1:0];
        quot_next_c = {quot[DW-2:0], fits};
    end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider for DIV/DIVU, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            signed_div_i,
    input  logic [DW-1:0]   opdata1_i,
    input  logic [DW-1:0]   opdata2_i,
    input  logic            start_i,
    input  logic            annul_i,
    output logic [2*DW-1:0] result_o,
    output logic            ready_o
);

    localparam int unsigned CW = $clog2(DW) + 1;

    div_state_e     state;
    logic [CW-1:0]  cnt;
    logic [DW-1:0]  rem_q;
    logic [DW-1:0]  quot_q;
    logic [DW-1:0]  divisor_q;
    logic           neg_quot_q;
    logic           neg_rem_q;

    logic [DW-1:0]  op1_abs;
    logic [DW-1:0]  op2_abs;
    logic [DW-1:0]  rem_step;
    logic [DW-1:0]  quot_step;
    logic [DW-1:0]  rem_fix;
    logic [DW-1:0]  quot_fix;
    logic           early_out;

    // Magnitudes of the incoming operands and sign correction of the final step.
    always_comb begin
        op1_abs  = (signed_div_i && opdata1_i[DW-1]) ? -opdata1_i : opdata1_i;
        op2_abs  = (signed_div_i && opdata2_i[DW-1]) ? -opdata2_i : opdata2_i;
        quot_fix = neg_quot_q ? -quot_step : quot_step;
        rem_fix  = neg_rem_q  ? -rem_step  : rem_step;
    end

`ifdef DIV_EARLY_OUT_EN
    assign early_out = (op1_abs < op2_abs);
`else
    assign early_out = 1'b0;
`endif

    div_step #(.DW(DW)) u_step (
        .rem         (rem_q),
        .quot        (quot_q),
        .divisor     (divisor_q),
        .rem_next_c  (rem_step),
        .quot_next_c (quot_step)
    );

    // Control FSM plus datapath registers; annul aborts from any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state      <= DIV_FREE;
            cnt        <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_o   <= '0;
            ready_o    <= DIV_RESULT_NOT_READY;
        end else if (annul_i) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            case (state)
                DIV_FREE: begin
                    result_o <= '0;
                    ready_o  <= DIV_RESULT_NOT_READY;
                    if (start_i == DIV_START) begin
                        cnt <= '0;
                        if (opdata2_i == '0) begin
                            state  <= DIV_BY_ZERO;
                            rem_q  <= '0;
                            quot_q <= '0;
                        end else if (early_out) begin
                            // Quotient is zero; remainder is the dividend as given.
                            state  <= DIV_BY_ZERO;
                            rem_q  <= opdata1_i;
                            quot_q <= '0;
                        end else begin
                            state      <= DIV_ON;
                            rem_q      <= '0;
                            quot_q     <= op1_abs;
                            divisor_q  <= op2_abs;
                            neg_quot_q <= signed_div_i & (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
                            neg_rem_q  <= signed_div_i & opdata1_i[DW-1];
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    state    <= DIV_END;
                    result_o <= {rem_q, quot_q};
                    ready_o  <= DIV_RESULT_READY;
                end
                DIV_ON: begin
                    rem_q  <= rem_step;
                    quot_q <= quot_step;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(DW - 1)) begin
                        state    <= DIV_END;
                        result_o <= {rem_fix, quot_fix};
                        ready_o  <= DIV_RESULT_READY;
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP) begin
                        state    <= DIV_FREE;
                        result_o <= '0;
                        ready_o  <= DIV_RESULT_NOT_READY;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Randomized and directed self-checking bench for div_iter against an arithmetic model.
module tb_div_iter;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

    div_iter #(.DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result {rem, quot} from plain integer arithmetic.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        int q;
        int r;
        if (b == 32'd0) return 64'd0;
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a;
        sb = b;
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
    endfunction

    // Edges after acceptance until ready_o is high.
    function automatic int ref_lat(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint ma;
        longint mb;
        if (b == 32'd0) return 1;
        ma = (sgn && a[31]) ? 64'd4294967296 - longint'(a) : longint'(a);
        mb = (sgn && b[31]) ? 64'd4294967296 - longint'(b) : longint'(b);
        if (EARLY_EN && ma < mb) return 1;
        return 32;
    endfunction

    // Full handshake: start held, operands scrambled after acceptance, hold, release.
    task automatic do_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] got);
        int lat;
        logic [63:0] exp;
        exp = ref_div(sgn, a, b);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        signed_div_i = 1'($urandom);
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        lat = 0;
        while (!ready_o && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", 64'(lat), 64'(ref_lat(sgn, a, b)));
        check_eq("result", result_o, exp);
        got = result_o;
        @(posedge clk);
        #1;
        check_eq("hold_ready", 64'(ready_o), 64'd1);
        check_eq("hold_result", result_o, exp);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check_eq("release_ready", 64'(ready_o), 64'd0);
        check_eq("release_result", result_o, 64'd0);
    endtask

    task automatic watch_no_ready(input string tag);
        bit seen;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1'b1;
        end
        check_eq(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [63:0] got;
        logic [31:0] a;
        logic [31:0] b;
        bit          sgn;
        int          lat;

        rst = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        start_i = 1'b0;
        annul_i = 1'b0;
        #1;
        check_eq("reset_ready", 64'(ready_o), 64'd0);
        check_eq("reset_result", result_o, 64'd0);
        #22;
        rst = 1'b0;

        do_op(1'b0, 32'd100, 32'd7, got);
        check_eq("divu_100_7", got, {32'd2, 32'd14});
        do_op(1'b1, -32'sd7, 32'd2, got);
        check_eq("div_m7_2", got, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op(1'b1, 32'd7, -32'sd2, got);
        check_eq("div_7_m2", got, {32'd1, 32'hFFFF_FFFD});
        do_op(1'b1, 32'd1234, 32'd0, got);
        check_eq("div_by_zero", got, 64'd0);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, got);
        check_eq("div_min_m1", got, {32'd0, 32'h8000_0000});
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, got);
        check_eq("divu_min_m1", got, {32'h8000_0000, 32'd0});
        do_op(1'b0, 32'd3, 32'd5, got);
        check_eq("divu_3_5", got, {32'd3, 32'd0});
        do_op(1'b1, -32'sd3, 32'd5, got);
        check_eq("div_m3_5", got, {32'hFFFF_FFFD, 32'd0});

        for (int i = 0; i < 16; i++) begin
            sgn = 1'($urandom);
            a = $urandom;
            case ($urandom % 4)
                0: b = $urandom;
                1: b = $urandom_range(1, 20);
                2: b = -$urandom_range(1, 20);
                default: b = a >> $urandom_range(0, 8);
            endcase
            if (i == 5) a = 32'd0;
            do_op(sgn, a, b, got);
        end

        // Start dropped mid-operation: result still arrives, ready for one cycle only.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd33;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (!ready_o && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 3) start_i = 1'b0;
        end
        check_eq("drop_latency", 64'(lat), 64'd32);
        check_eq("drop_result", result_o, {32'd10, 32'd30});
        @(posedge clk);
        #1;
        check_eq("drop_ready_once", 64'(ready_o), 64'd0);

        // Annul part way through the iterations.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i = 32'd999;
        opdata2_i = 32'd4;
        start_i = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        check_eq("annul_ready", 64'(ready_o), 64'd0);
        watch_no_ready("annul_no_ready");
        do_op(1'b0, 32'd999, 32'd4, got);
        check_eq("after_annul", got, {32'd3, 32'd249});

        // Asynchronous reset in the middle of the iterations.
        @(negedge clk);
        opdata1_i = 32'd50;
        opdata2_i = 32'd6;
        start_i = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("rst_on_ready", 64'(ready_o), 64'd0);
        check_eq("rst_on_result", result_o, 64'd0);
        start_i = 1'b0;
        #3;
        rst = 1'b0;
        watch_no_ready("rst_no_ready");

        // Asynchronous reset while a result is being presented.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i = 1'b1;
        lat = 0;
        while (!ready_o && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("end_ready", 64'(ready_o), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check_eq("rst_end_ready", 64'(ready_o), 64'd0);
        check_eq("rst_end_result", result_o, 64'd0);
        start_i = 1'b0;
        #2;
        rst = 1'b0;

        do_op(1'b1, -32'sd100, -32'sd7, got);
        check_eq("div_m100_m7", got, {32'hFFFF_FFFE, 32'd14});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
